// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB destinations to produce stall, flush and operand-forward selects.
// Define HAZARD_CTRL_FORWARDING_EN to enable forwarding; otherwise consumers stall until the producer retires.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_en,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_en;
        logic       is_load;
    } slot_t;

    function automatic logic slot_match(input slot_t s, input logic [4:0] src, input logic use_src);
        return s.valid & s.rf_en & (s.rd == src) & (src != 5'd0) & use_src;
    endfunction

    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic ex_a, ex_b, mem_a, mem_b;
    logic hazard;
    logic unused_wb;

    assign ex_a  = slot_match(ex_q,  id_rs1, id_use_rs1);
    assign ex_b  = slot_match(ex_q,  id_rs2, id_use_rs2);
    assign mem_a = slot_match(mem_q, id_rs1, id_use_rs1);
    assign mem_b = slot_match(mem_q, id_rs2, id_use_rs2);

`ifdef HAZARD_CTRL_FORWARDING_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    // Only a load still in EX cannot be forwarded in time; one bubble moves it to MEM.
    assign hazard = ex_q.is_load & (ex_a | ex_b);

    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (id_valid && !bubble_ex) begin
            if (ex_a)       fwd_a_d = 2'b01;
            else if (mem_a) fwd_a_d = 2'b10;
            if (ex_b)       fwd_b_d = 2'b01;
            else if (mem_b) fwd_b_d = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
`else
    logic wb_a, wb_b;

    assign wb_a   = slot_match(wb_q, id_rs1, id_use_rs1);
    assign wb_b   = slot_match(wb_q, id_rs2, id_use_rs2);
    assign hazard = ex_a | ex_b | mem_a | mem_b | wb_a | wb_b;
    assign fwd_a  = 2'b00;
    assign fwd_b  = 2'b00;
`endif

    // Gated by rst so nothing leaks out while the block is held in reset.
    assign stall     = rst & id_valid & hazard & ~ex_redirect;
    assign flush_id  = rst & ex_redirect;
    assign bubble_ex = stall | flush_id;

    // WB slot mirrors the pipeline but its is_load (and, with forwarding, the whole slot) has no consumer.
    assign unused_wb = ^wb_q;

    always_comb begin
        ex_d  = bubble_ex ? slot_t'('0) : slot_t'({id_valid, id_rd, id_rf_en, id_is_load});
        mem_d = ex_q;
        wb_d  = mem_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        flush_cnt_d = flush_cnt_q;
        if (flush_id && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver queues hand-computed expectations per cycle,
// a monitor pops and compares them on the falling edge.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CW = 4;
    localparam int EW = 3 + 4 + 2 * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid, id_use_rs1, id_use_rs2, id_rf_en, id_is_load, ex_redirect;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          stall, flush_id, bubble_ex;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            total = 0;
    int            bad = 0;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rf_en(id_rf_en),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(stall), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // clock
    always #5 clk = ~clk;

    // driver: apply one cycle of ID inputs and queue what the outputs must be during that cycle
    task automatic cyc(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rf, input logic ld, input logic redir,
                       input logic e_s, input logic e_f, input logic e_b, input logic [1:0] e_fa,
                       input logic [1:0] e_fb, input logic [CW-1:0] e_sc, input logic [CW-1:0] e_fc,
                       input string nm);
        id_valid    = v;
        id_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_rf_en    = rf;
        id_is_load  = ld;
        ex_redirect = redir;
        exp_q.push_back({e_s, e_f, e_b, e_fa, e_fb, e_sc, e_fc});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] e_fa, input logic [CW-1:0] e_sc, input logic [CW-1:0] e_fc,
                        input string nm);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_fa, 2'b00, e_sc, e_fc, nm);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2'b00, 0, 0, "reset_clear");
        rst = 1'b1;
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // monitor / scoreboard
    initial begin
        logic [EW-1:0] e, a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {stall, flush_id, bubble_ex, fwd_a, fwd_b, stall_cnt, flush_cnt};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s got {stall,flush,bubble,fa,fb,scnt,fcnt}=%b_%b_%b_%b_%b_%0d_%0d want %b_%b_%b_%b_%b_%0d_%0d",
                             nm, a[EW-1], a[EW-2], a[EW-3], a[EW-4 -: 2], a[EW-6 -: 2], a[2*CW-1 -: CW], a[CW-1:0],
                             e[EW-1], e[EW-2], e[EW-3], e[EW-4 -: 2], e[EW-6 -: 2], e[2*CW-1 -: CW], e[CW-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CW-1:0] sc;
        int iters, n;
        id_valid = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rf_en = 0; id_is_load = 0; ex_redirect = 0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        // outputs held low in reset even with a redirect and a real instruction present
        cyc(1, 7, 7, 7, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "reset_gating");
        idle(2'b00, 0, 0, "reset_idle");
        rst = 1'b1;

`ifndef HAZARD_CTRL_FORWARDING_EN
        // add x5 ; sub x9,x5,x5 -> three stall cycles until x5 retires
        cyc(1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "raw_prod");
        cyc(1, 9, 5, 5, 1, 1, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, "raw_stall1");
        cyc(1, 9, 5, 5, 1, 1, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 1, 0, "raw_stall2");
        cyc(1, 9, 5, 5, 1, 1, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2, 0, "raw_stall3");
        cyc(1, 9, 5, 5, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3, 0, "raw_release");
        idle(2'b00, 3, 0, "raw_drain");
`else
        // add x5 ; add x6,x5,x1 -> no stall, consumer sees EX/MEM forward on rs1
        cyc(1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "fwd_prod");
        cyc(1, 6, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "fwd_cons");
        idle(2'b01, 0, 0, "fwd_ex");
        idle(2'b00, 0, 0, "fwd_drain");
        // lw x7 ; add x8,x7,x7 -> one stall, then WB forward on both operands
        cyc(1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "lu_prod");
        cyc(1, 8, 7, 7, 1, 1, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, "lu_stall");
        cyc(1, 8, 7, 7, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, "lu_go");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, "lu_fwd");
        idle(2'b00, 1, 0, "lu_drain");
`endif

        // x0 producer and x0 consumer never interact
        do_reset();
        cyc(1, 0, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "x0_prod");
        cyc(1, 3, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "x0_cons");
        idle(2'b00, 0, 0, "x0_ex");
        idle(2'b00, 0, 0, "x0_drain");

        // load-use hazard in the same cycle as a redirect: redirect wins
        do_reset();
        cyc(1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "ldr_prod");
        cyc(1, 8, 7, 7, 1, 1, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00, 0, 0, "ldr_redirect");
        idle(2'b00, 0, 1, "ldr_after");
        idle(2'b00, 0, 1, "ldr_drain");

`ifndef HAZARD_CTRL_FORWARDING_EN
        // reset dropped part-way through the second stall cycle
        do_reset();
        cyc(1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "mr_prod");
        cyc(1, 9, 5, 5, 1, 1, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, "mr_stall1");
        fork
            begin #6; rst = 1'b0; end
        join_none
        cyc(1, 9, 5, 5, 1, 1, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 1, 0, "mr_stall2");
        cyc(1, 9, 5, 5, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "mr_in_reset");
        rst = 1'b1;
        idle(2'b00, 0, 0, "mr_release");
        idle(2'b00, 0, 0, "mr_idle");
        cyc(1, 9, 5, 5, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "mr_no_residual");
        idle(2'b00, 0, 0, "mr_drain");
`endif

        // flush counter saturates at all-ones
        do_reset();
        for (int i = 0; i < 17; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00, 2'b00, 0, (i > 15) ? 4'd15 : CW'(i), "flush_sat");
        idle(2'b00, 0, 15, "flush_hold");

        // stall counter saturates while stalls keep behaving normally
        do_reset();
        sc    = 0;
        n     = FWD ? 1 : 3;
        iters = FWD ? 17 : 6;
        for (int k = 0; k < iters; k++) begin
            cyc(1, 7, 0, 0, 0, 0, 1, FWD, 0, 0, 0, 0, (FWD && k > 0) ? 2'b10 : 2'b00, 2'b00, sc, 0, "sat_prod");
            for (int j = 0; j < n; j++) begin
                cyc(1, 8, 7, 0, 1, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, sc, 0, "sat_stall");
                sc = sat_inc(sc);
            end
            cyc(1, 8, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, sc, 0, "sat_go");
        end
        idle(FWD ? 2'b10 : 2'b00, 15, 0, "sat_hold");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
